// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer: scans enabled channels in ascending
// order, runs track/hold + binary search per sample, and averages 2^avg samples.
module sar_adc_seq #(
    parameter int RES_BITS   = 10,
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_CYC = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic [NUM_CH-1:0]   ch_mask_i,
    input  logic [1:0]          avg_log2_i,
    input  logic                cont_i,
    input  logic                cmp_i,
    output logic                sample_o,
    output logic [CH_W-1:0]     ch_sel_o,
    output logic [RES_BITS-1:0] dac_o,
    output logic                busy_o,
    output logic [RES_BITS-1:0] data_o,
    output logic [CH_W-1:0]     data_ch_o,
    output logic                valid_o,
    output logic                scan_done_o
);

    localparam int TW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam int BW = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
    localparam int AW = RES_BITS + 3;
    localparam logic [RES_BITS-1:0] ONE = RES_BITS'(1);
    localparam logic [RES_BITS-1:0] MSB = ONE << (RES_BITS - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t              state;
    logic                rst_sync;
    logic [TW-1:0]       tmr;
    logic [BW-1:0]       bit_idx;
    logic [RES_BITS-1:0] code;
    logic [AW-1:0]       acc;
    logic [2:0]          cnt;
    logic [NUM_CH-1:0]   mask_q;
    logic [1:0]          avg_q;
    logic                cont_q;

    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     start_ch;
    logic [CH_W-1:0]     nxt_ch;
    logic                nxt_found;
    logic [RES_BITS-1:0] code_n;
    logic [RES_BITS-1:0] trial_next;
    logic [AW-1:0]       sum;
    logic                last_sample;

    // Reset asserts asynchronously through rst_sync but releases on a clock edge,
    // so the FSM leaves reset one edge after wb_rst_i drops.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) rst_sync <= 1'b1;
        else          rst_sync <= 1'b0;
    end

    // Descending scan so the last hit is the lowest qualifying channel.
    always_comb begin
        first_ch  = '0;
        start_ch  = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mask_q[i-1])    first_ch = CH_W'(i - 1);
            if (ch_mask_i[i-1]) start_ch = CH_W'(i - 1);
            if (mask_q[i-1] && ((i - 1) > 32'(ch_sel_o))) begin
                nxt_ch    = CH_W'(i - 1);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        code_n      = cmp_i ? dac_o : code;
        trial_next  = ONE << (bit_idx - BW'(1));
        sum         = acc + AW'(code);
        last_sample = (({1'b0, cnt} + 4'd1) == (4'd1 << avg_q));
    end

    always_ff @(posedge wb_clk_i or posedge rst_sync) begin
        if (rst_sync) begin
            state       <= IDLE;
            tmr         <= '0;
            bit_idx     <= '0;
            code        <= '0;
            acc         <= '0;
            cnt         <= '0;
            mask_q      <= '0;
            avg_q       <= '0;
            cont_q      <= 1'b0;
            sample_o    <= 1'b0;
            ch_sel_o    <= '0;
            dac_o       <= '0;
            busy_o      <= 1'b0;
            data_o      <= '0;
            data_ch_o   <= '0;
            valid_o     <= 1'b0;
            scan_done_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            scan_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && (|ch_mask_i)) begin
                        mask_q   <= ch_mask_i;
                        avg_q    <= avg_log2_i;
                        cont_q   <= cont_i;
                        ch_sel_o <= start_ch;
                        tmr      <= '0;
                        acc      <= '0;
                        cnt      <= '0;
                        dac_o    <= '0;
                        sample_o <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (tmr == TW'(SAMPLE_CYC - 1)) begin
                        sample_o <= 1'b0;
                        bit_idx  <= BW'(RES_BITS - 1);
                        code     <= '0;
                        dac_o    <= MSB;
                        state    <= CONVERT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                CONVERT: begin
                    code <= code_n;
                    if (bit_idx == '0) begin
                        dac_o <= code_n;
                        state <= DONE;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                        dac_o   <= code_n | trial_next;
                    end
                end
                DONE: begin
                    tmr   <= '0;
                    dac_o <= '0;
                    if (!last_sample) begin
                        cnt      <= cnt + 1'b1;
                        acc      <= sum;
                        sample_o <= 1'b1;
                        state    <= SAMPLE;
                    end else begin
                        data_o    <= RES_BITS'(sum >> avg_q);
                        data_ch_o <= ch_sel_o;
                        valid_o   <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        if (nxt_found) begin
                            ch_sel_o <= nxt_ch;
                            sample_o <= 1'b1;
                            state    <= SAMPLE;
                        end else begin
                            // Scan end: continue only while cont_i stays asserted.
                            scan_done_o <= 1'b1;
                            cont_q      <= cont_i;
                            if (cont_q && cont_i) begin
                                ch_sel_o <= first_ch;
                                sample_o <= 1'b1;
                                state    <= SAMPLE;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Bench for sar_adc_seq: ideal comparator driven from a per-sample Vin table,
// directed vector table plus randomized scans checked against an averaging model.
module tb_sar_adc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] mask = '0;
    logic [1:0] avg = '0;
    logic       cont = 1'b0;
    logic       cmp;
    logic       sample;
    logic [1:0] ch_sel;
    logic [9:0] dac;
    logic       busy;
    logic [9:0] data;
    logic [1:0] data_ch;
    logic       valid;
    logic       scan_done;

    sar_adc_seq #(.RES_BITS(10), .NUM_CH(4), .SAMPLE_CYC(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .ch_mask_i(mask),
        .avg_log2_i(avg), .cont_i(cont), .cmp_i(cmp), .sample_o(sample),
        .ch_sel_o(ch_sel), .dac_o(dac), .busy_o(busy), .data_o(data),
        .data_ch_o(data_ch), .valid_o(valid), .scan_done_o(scan_done)
    );

    always #5 clk = ~clk;

    // Analog side: each new track phase takes the next Vin from the table.
    logic [9:0] vin_tab [0:255];
    logic [9:0] cur_vin = '0;
    int         gs = 0;
    logic       prev_s = 1'b0;

    always @(negedge clk) begin
        if (!busy) gs = 0;
        else if (sample && !prev_s) begin
            cur_vin = vin_tab[gs[7:0]];
            gs = gs + 1;
        end
        prev_s = sample;
    end

    assign cmp = (cur_vin >= dac);

    int passed = 0;
    int total = 0;

    int         obs_t[$];
    logic [9:0] obs_d[$];
    logic [1:0] obs_c[$];
    logic       obs_done[$];
    int         exp_t[$];
    logic [9:0] exp_d[$];
    logic [1:0] exp_c[$];
    logic       exp_done[$];

    typedef struct {
        logic [3:0]       mask;
        logic [1:0]       avg;
        logic [3:0][9:0]  v;
        logic [9:0]       exp_data;
        logic [1:0]       exp_ch;
        int               exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic check_reset(input string p);
        check({p, "_sample"},    32'(sample), 32'd0);
        check({p, "_ch_sel"},    32'(ch_sel), 32'd0);
        check({p, "_dac"},       32'(dac), 32'd0);
        check({p, "_busy"},      32'(busy), 32'd0);
        check({p, "_data"},      32'(data), 32'd0);
        check({p, "_data_ch"},   32'(data_ch), 32'd0);
        check({p, "_valid"},     32'(valid), 32'd0);
        check({p, "_scan_done"}, 32'(scan_done), 32'd0);
    endtask

    task automatic start_scan(input logic [3:0] m, input logic [1:0] a, input logic c);
        @(negedge clk);
        mask = m; avg = a; cont = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records every valid_o with its cycle number relative to the start edge.
    task automatic collect(input int ncyc, input int drop_cont_at, input int poke_at);
        obs_t.delete(); obs_d.delete(); obs_c.delete(); obs_done.delete();
        for (int t = 1; t <= ncyc; t++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                obs_t.push_back(t); obs_d.push_back(data);
                obs_c.push_back(data_ch); obs_done.push_back(scan_done);
            end
            if (t == drop_cont_at) cont = 1'b0;
            if (t == poke_at) begin start = 1'b1; mask = 4'hF; avg = 2'd3; end
            if (t == poke_at + 1) start = 1'b0;
        end
    endtask

    // Reference: each enabled channel, in ascending order, consumes 2^avg
    // consecutive table entries; result is their integer mean, 13 cycles per sample.
    task automatic build_exp(input logic [3:0] m, input logic [1:0] a, input int scans);
        int g, t, n, s, sum, last;
        exp_t.delete(); exp_d.delete(); exp_c.delete(); exp_done.delete();
        g = 0; t = 0; n = 1 << a; last = 0;
        for (int ch = 0; ch < 4; ch++) if (m[ch]) last = ch;
        for (s = 0; s < scans; s++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (m[ch]) begin
                    sum = 0;
                    for (int j = 0; j < n; j++) begin
                        sum += int'(vin_tab[g]);
                        g++;
                    end
                    t += n * (2 + 10 + 1);
                    exp_t.push_back(t);
                    exp_d.push_back(10'(sum / n));
                    exp_c.push_back(2'(ch));
                    exp_done.push_back(ch == last);
                end
            end
        end
    endtask

    task automatic compare_obs(input string p);
        int n;
        check({p, "_nvalid"}, 32'(obs_t.size()), 32'(exp_t.size()));
        n = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", p, i),  32'(obs_t[i]), 32'(exp_t[i]));
            check($sformatf("%s_data%0d", p, i), 32'(obs_d[i]), 32'(exp_d[i]));
            check($sformatf("%s_ch%0d", p, i),   32'(obs_c[i]), 32'(exp_c[i]));
            check($sformatf("%s_done%0d", p, i), 32'(obs_done[i]), 32'(exp_done[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0001, 2'd0, {10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5}, 10'h2A5, 2'd0, 13};
        vecs[1] = '{4'b0100, 2'd0, {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 10'h3FF, 2'd2, 13};
        vecs[2] = '{4'b0001, 2'd2, {10'd103, 10'd102, 10'd101, 10'd100}, 10'd101, 2'd0, 52};
        vecs[3] = '{4'b1000, 2'd1, {10'd0, 10'd0, 10'd1, 10'd0}, 10'd0, 2'd3, 26};
        vecs[4] = '{4'b0010, 2'd3, {10'h3FE, 10'h3FF, 10'h3FF, 10'h3FF}, 10'h3FE, 2'd1, 104};
        vecs[5] = '{4'b0001, 2'd1, {10'h000, 10'h000, 10'h2AA, 10'h155}, 10'h1FF, 2'd0, 26};
        vecs[6] = '{4'b0100, 2'd0, {10'h000, 10'h000, 10'h000, 10'h000}, 10'h000, 2'd2, 13};
        vecs[7] = '{4'b0001, 2'd0, {10'h200, 10'h200, 10'h200, 10'h200}, 10'h200, 2'd0, 13};
        for (int i = 0; i < 256; i++) vin_tab[i] = '0;

        #2 rst = 1'b1;
        @(negedge clk);
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Directed single-channel vectors
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) vin_tab[j] = vecs[i].v[j[1:0]];
            start_scan(vecs[i].mask, vecs[i].avg, 1'b0);
            collect(vecs[i].exp_lat + 3, -1, -1);
            check($sformatf("vec%0d_nvalid", i), 32'(obs_t.size()), 32'd1);
            if (obs_t.size() > 0) begin
                check($sformatf("vec%0d_cyc", i),  32'(obs_t[0]), 32'(vecs[i].exp_lat));
                check($sformatf("vec%0d_data", i), 32'(obs_d[0]), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_ch", i),   32'(obs_c[0]), 32'(vecs[i].exp_ch));
                check($sformatf("vec%0d_done", i), 32'(obs_done[0]), 32'd1);
            end
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Two channels, scan_done only on the last
        vin_tab[0] = 10'h3FF; vin_tab[1] = 10'h000;
        build_exp(4'b1010, 2'd0, 1);
        start_scan(4'b1010, 2'd0, 1'b0);
        collect(30, -1, -1);
        compare_obs("two_ch");

        // Continuous mode, cont dropped during channel 0 of the third scan
        for (int i = 0; i < 16; i++) vin_tab[i] = 10'($urandom);
        build_exp(4'b0011, 2'd0, 3);
        start_scan(4'b0011, 2'd0, 1'b1);
        collect(90, 58, -1);
        compare_obs("cont");
        check("cont_idle", 32'(busy), 32'd0);

        // start while busy must not disturb the running scan
        vin_tab[0] = 10'h0AB;
        build_exp(4'b0001, 2'd0, 1);
        start_scan(4'b0001, 2'd0, 1'b0);
        collect(20, -1, 4);
        compare_obs("busy_start");
        check("busy_start_idle", 32'(busy), 32'd0);

        // start with an empty mask is ignored
        @(negedge clk);
        mask = 4'b0000; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mask0_busy", 32'(busy), 32'd0);
        check("mask0_sample", 32'(sample), 32'd0);
        start = 1'b0;

        // Reset in CONVERT cycle 5, then start honoured on the second edge
        vin_tab[0] = 10'h155;
        start_scan(4'b0001, 2'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_sample", 32'(sample), 32'd0);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0; mask = 4'b0001; avg = 2'd0; cont = 1'b0; start = 1'b1;
        vin_tab[0] = 10'h321;
        @(posedge clk);
        #1 check("rel_edge1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("rel_edge2_busy", 32'(busy), 32'd1);
        start = 1'b0;
        build_exp(4'b0001, 2'd0, 1);
        collect(16, -1, -1);
        compare_obs("post_rst");

        // Randomized single scans
        for (int r = 0; r < 8; r++) begin
            logic [3:0] m;
            logic [1:0] a;
            m = 4'($urandom_range(1, 15));
            a = 2'($urandom_range(0, 2));
            for (int i = 0; i < 64; i++) vin_tab[i] = 10'($urandom);
            build_exp(m, a, 1);
            start_scan(m, a, 1'b0);
            collect(exp_t[exp_t.size() - 1] + 3, -1, -1);
            compare_obs($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_idle", r), 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sar_adc_seq.md
SAR_ADC_SEQ -- requirements
Module: sar_adc_seq

Interface
REQ-001 Parameter RES_BITS, default 10: conversion resolution in bits.
REQ-002 Parameter NUM_CH, default 4: number of analog channels; CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter SAMPLE_CYC, default 2, minimum 1: track/hold duration in clocks.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous assertion, active-high.
REQ-006 start_i  in  1  start scan; sampled only in IDLE.
REQ-007 ch_mask_i  in  NUM_CH  enabled channels; bit i enables channel i.
REQ-008 avg_log2_i  in  2  samples averaged per channel = 2^avg_log2_i (1, 2, 4, 8).
REQ-009 cont_i  in  1  continuous mode; scan restarts after the last channel.
REQ-010 cmp_i  in  1  comparator output; 1 = Vin >= DAC voltage.
REQ-011 sample_o  out  1  S/H track enable.
REQ-012 ch_sel_o  out  CH_W  analog mux select.
REQ-013 dac_o  out  RES_BITS  SAR DAC trial code.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 data_o  out  RES_BITS  averaged result; held until the next valid_o.
REQ-016 data_ch_o  out  CH_W  channel of data_o.
REQ-017 valid_o  out  1  one-cycle pulse; data_o and data_ch_o are new in that cycle.
REQ-018 scan_done_o  out  1  one-cycle pulse after the last enabled channel of each scan.

Function
REQ-019 FSM states: IDLE, SAMPLE, CONVERT, DONE.
REQ-020 IDLE -> SAMPLE when start_i=1 and ch_mask_i!=0; ch_mask_i, avg_log2_i and cont_i are latched on that edge.
- start_i with ch_mask_i=0 is ignored; the block stays in IDLE.
REQ-021 start_i while busy_o=1 is ignored; latched configuration is unchanged until the next IDLE exit.
REQ-022 Channel order: ascending index over the latched mask; ch_sel_o is stable from SAMPLE entry through DONE.
REQ-023 SAMPLE: exactly SAMPLE_CYC cycles; sample_o=1; dac_o=0.
REQ-024 CONVERT: exactly RES_BITS cycles; sample_o=0.
- Cycle k (k=0..RES_BITS-1) presents dac_o = decided bits | trial bit (RES_BITS-1-k).
- cmp_i is sampled at the end of the cycle; the trial bit is kept if cmp_i=1 and cleared otherwise.
REQ-025 DONE: 1 cycle; the final code is added into accumulator acc (width RES_BITS+3).
- If the sample count is below 2^avg_log2: next state is SAMPLE, same channel.
- Otherwise: data_o = (acc + code) >> avg_log2 (truncating), valid_o=1, acc cleared, advance to the next channel.
REQ-026 After the last enabled channel's DONE: scan_done_o=1 in the same cycle as valid_o.
- cont_i latched 1: go to SAMPLE of the lowest enabled channel.
- Otherwise: go to IDLE.
- cont_i is re-latched at each scan end; deasserting cont_i lets the current scan finish, then the block idles.
REQ-027 Latency from the edge sampling start_i to valid_o is 2^avg_log2 x (SAMPLE_CYC+RES_BITS+1) cycles; default 13 per sample.
REQ-028 No overflow is possible: 8 x (2^RES_BITS-1) fits in RES_BITS+3 bits.

Reset
REQ-029 wb_rst_i=1 forces IDLE immediately, including mid-conversion.
- Reset values: sample_o=0, ch_sel_o=0, dac_o=0, busy_o=0, data_o=0, data_ch_o=0, valid_o=0, scan_done_o=0.
- acc, sample count and latched configuration are cleared.
REQ-030 Deassertion is synchronised to wb_clk_i; start_i is honoured from the second edge after release.

Verification
REQ-031 Defaults, mask=0001, avg=0, comparator model Vin=0x2A5 -> valid_o at cycle 13 after start; data_o=0x2A5, data_ch_o=0, scan_done_o=1; busy_o low the next cycle.
REQ-032 Mask=1010, avg=0, Vin ch1=0x3FF, ch3=0x000 -> valid_o at cycles 13 (0x3FF, ch1) and 26 (0x000, ch3); scan_done_o only at 26.
REQ-033 Mask=0001, avg=2, per-sample Vin 100,101,102,103 -> a single valid_o at cycle 52; data_o=101.
REQ-034 cont_i=1, mask=0011 -> valid_o for ch0, ch1, ch0, ch1 ...; dropping cont_i during ch0 of scan 3 -> scan 3 completes, then IDLE.
REQ-035 Assert wb_rst_i at CONVERT cycle 5 -> all outputs at reset values immediately; start_i during busy is ignored, and start_i with mask=0 is ignored.
